// File: rtl/restoring_divider_8bit.sv
// restoring_divider_8bit
//   Sequential restoring divider, one quotient bit per clock, MSB first.
//   The result is packed as {remainder, quotient} with a divide-by-zero flag
//   on carry, matching the ALU result/carry shape so the two can share a mux.
//
//   Optional feature macro: DIVIDER_SIGNED_EN
//     undefined : unsigned operands only
//     defined   : two's-complement operands, truncating division
//                 (quotient rounds toward zero, remainder takes sign of a)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while idle
//   a      in   dividend, captured on the accept edge
//   b      in   divisor, captured on the accept edge
//   busy   out  high while iterating
//   done   out  one-cycle pulse, result valid
//   result out  {remainder, quotient}, held until next accept or reset
//   carry  out  divide-by-zero flag, held alongside result
module restoring_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               carry
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dsr_q, dsr_d;      // divisor
    logic [WIDTH:0]     rem_q, rem_d;      // partial remainder R
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               carry_q, carry_d;

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic               q_bit;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

`ifdef DIVIDER_SIGNED_EN
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
`endif

    always_comb begin
        // One restoring step: shift in the next dividend bit, trial-subtract.
        rem_sh   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        diff     = {1'b0, rem_sh} - {2'b00, dsr_q};
        q_bit    = ~diff[WIDTH+1];
        rem_next = q_bit ? diff[WIDTH:0] : rem_sh;
        quo_next = {dvd_q[WIDTH-2:0], q_bit};

`ifdef DIVIDER_SIGNED_EN
        a_mag   = a[WIDTH-1] ? ((~a) + WIDTH'(1)) : a;
        b_mag   = b[WIDTH-1] ? ((~b) + WIDTH'(1)) : b;
        quo_fix = (sign_a_q ^ sign_b_q) ? ((~quo_next) + WIDTH'(1)) : quo_next;
        rem_fix = sign_a_q ? ((~rem_next[WIDTH-1:0]) + WIDTH'(1)) : rem_next[WIDTH-1:0];
`else
        a_mag   = a;
        b_mag   = b;
        quo_fix = quo_next;
        rem_fix = rem_next[WIDTH-1:0];
`endif

        state_d  = state_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        carry_d  = carry_q;
`ifdef DIVIDER_SIGNED_EN
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = a_mag;
                    dsr_d = b_mag;
                    rem_d = '0;
                    cnt_d = '0;
`ifdef DIVIDER_SIGNED_EN
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b[WIDTH-1];
`endif
                    if (b != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        state_d  = DONE;
                        result_d = {a, {WIDTH{1'b1}}};
                        carry_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                dvd_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = {rem_fix, quo_fix};
                    carry_d  = 1'b0;
                end
            end
            DONE: begin
                // Arriving from RUN the pulse is already up, so leave at once.
                // Arriving straight from IDLE (divide by zero) the pulse has not
                // fired yet: raise it now and leave on the following edge.
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            carry_q  <= carry_d;
`ifdef DIVIDER_SIGNED_EN
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;

endmodule

// File: doc/restoring_divider_8bit.md
# restoring_divider_8bit

Sequential restoring divider that computes the quotient and remainder of two operands over several cycles with a start/done handshake. It is the inverse of the combinational array multiplier, and it is the datapath's division unit. The result is packed into the same 16-bit result / 1-bit carry shape the ALU drives, so it can sit beside the ALU on a common result mux.

## Interface
- WIDTH, 8, operand width; result width is 2*WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  dividend; captured on the accept edge.
- b  input  WIDTH  divisor; captured on the accept edge.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse: result valid.
- result  output  2*WIDTH  {remainder, quotient}; held until the next accept or reset.
- carry  output  1  divide-by-zero flag; held alongside result.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: capture a and b, clear the partial remainder R (WIDTH+1 bits) and the iteration count.
  - b != 0: go to RUN.
  - b == 0: go directly to DONE.
- IDLE, start=0: stay in IDLE.
- RUN, one iteration per cycle, MSB first, WIDTH iterations:
  - Shift R left, bringing in the next dividend bit.
  - Compute T = R - {0,b}.
  - T is non-negative: R = T, quotient bit = 1.
  - T is negative: R is restored (left as shifted), quotient bit = 0.
- After the WIDTH-th iteration: register result = {R[WIDTH-1:0], Q} and carry=0, then go to DONE.
- DONE: done=1 for this cycle only, then go to IDLE unconditionally.
- Divide by zero: result = {a, {WIDTH{1'b1}}}, meaning quotient all-ones and remainder = dividend. carry=1.
- start is ignored in RUN and DONE: no queuing and no restart.
- Operand inputs are don't-care outside the accept edge.
- Arithmetic is unsigned modulo 2^WIDTH. The quotient never overflows when b != 0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, carry=0, and all internal registers 0.
- rst takes priority over everything. Asserting it mid-RUN aborts the operation, clears result and carry, and produces no done pulse.
- Edge numbering: the accept edge is E0.
- b != 0:
  - busy is high in the cycles after edges E0 through E(WIDTH-1).
  - result and carry update on edge E(WIDTH).
  - done is high in the cycle after E(WIDTH).
  - The block is back in IDLE after E(WIDTH+1).
- Latency from accept to done is WIDTH cycles; the default is 8.
- b == 0: done is high in the cycle after E1, busy never asserts, and latency is 1 cycle.
- Throughput: the next start can be accepted on the edge at which the block has returned to IDLE. That is WIDTH+2 edges per operation, or 3 edges for divide by zero.
- busy and done are never high in the same cycle.

## Configuration
- Macro DIVIDER_SIGNED_EN.
- Defined:
  - a and b are two's complement.
  - On accept, magnitudes are captured and the signs latched.
  - On the DONE-entry edge, the quotient is negated if sign(a) != sign(b), and the remainder takes sign(a). The quotient truncates toward zero.
  - Most-negative / -1 wraps: quotient = most-negative, remainder 0, carry=0.
  - Divide by zero keeps the unsigned rule: quotient all-ones, remainder = a.
  - Latency is unchanged.
- Undefined: unsigned-only datapath with no sign logic.

## Test plan
- Basic unsigned (WIDTH=8): a=200, b=7, start pulse -> done exactly 8 cycles after accept, result=16'h041C (r=4, q=28), carry=0. busy high for 8 cycles.
- Boundaries: a=255, b=1 -> result=16'h00FF. a=3, b=10 -> result=16'h0300. a=0, b=255 -> result=16'h0000.
- Divide by zero: a=8'h05, b=0 -> done 1 cycle after accept, busy never high, result=16'h05FF, carry=1. carry returns to 0 on the next valid operation.
- Handshake: start held high continuously from 200/7 onward, with a=9, b=3 applied during RUN. Required response:
  - The first result is 16'h041C.
  - No restart occurs during RUN or DONE.
  - The next accept happens in IDLE and yields 16'h0003.
- Reset mid-operation: rst asserted 4 cycles into 200/7 -> next cycle IDLE, busy=0, result=0, carry=0, and no done pulse. A following 100/9 yields 16'h010B.
- DIVIDER_SIGNED_EN:
  - a=-7, b=2 -> result=16'hFFFD (r=-1, q=-3).
  - a=7, b=-2 -> 16'h01FD.
  - a=-128, b=-1 -> 16'h0080, carry=0.
